// File: rtl/char_pwm_gen.sv
// Character-pattern PWM driver for the pixel ASIC inputs and board LEDs.
// A prescaled tick steps a 16-step PWM frame; character changes take effect only at frame wrap.
module char_pwm_gen #(
    parameter int unsigned C_S_AXI_ACLK_FREQ_HZ = 100000000,
    parameter int unsigned FAST_DIV             = 1000,
    parameter int unsigned DUTY                 = 8
) (
    input  logic        S_AXI_ACLK,
    input  logic        Local_Reset,
    input  logic [1:0]  char_select,
    input  logic [15:0] direct_ctrl,
    input  logic [31:0] debug,
    input  logic [1:0]  network_output,
    output logic [15:0] digit_out,
    output logic [3:0]  led_out,
    output logic        frame_start
);
    localparam int unsigned MAX_DIV = (C_S_AXI_ACLK_FREQ_HZ > FAST_DIV) ? C_S_AXI_ACLK_FREQ_HZ : FAST_DIV;
    localparam int unsigned PRE_W   = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;

    localparam logic [PRE_W-1:0] SLOW_LAST = PRE_W'(C_S_AXI_ACLK_FREQ_HZ - 1);
    localparam logic [PRE_W-1:0] FAST_LAST = PRE_W'(FAST_DIV - 1);
    localparam logic [4:0]       DUTY_W    = 5'(DUTY);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [3:0]       pwm_q, pwm_d;
    logic [1:0]       char_q, char_d;
    logic             rate_q;
    logic [15:0]      digit_q, digit_d;
    logic [3:0]       led_q, led_d;
    logic             frame_q, frame_d;

    logic             rate_chg;
    logic             tick;
    logic             pwm_on;
    logic [PRE_W-1:0] pre_last;
    logic [15:0]      pattern;
    logic             unused_debug;

    assign unused_debug = ^debug[31:5];

    assign rate_chg = (debug[3] != rate_q);
    assign pre_last = debug[3] ? SLOW_LAST : FAST_LAST;
    // A rate change suppresses the tick so the clear always wins over a wrap.
    assign tick     = (state_q == S_RUN) && !rate_chg && (pre_q == pre_last);
    assign pwm_on   = ({1'b0, pwm_q} < DUTY_W);

    always_comb begin
        pattern = 16'h9669;
        case (char_q)
            2'd1:    pattern = 16'hF99F;
            2'd2:    pattern = 16'h6FF6;
            2'd3:    pattern = 16'h8421;
            default: pattern = 16'h9669;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        pwm_d   = pwm_q;
        char_d  = char_q;
        frame_d = 1'b0;
        digit_d = 16'h0000;
        led_d   = 4'h0;

        case (state_q)
            S_IDLE: begin
                pre_d = '0;
                pwm_d = '0;
                if (debug[4]) begin
                    state_d = S_RUN;
                    char_d  = char_select;
                end
            end
            default: begin
                if (!debug[4]) begin
                    state_d = S_IDLE;
                end
                if (rate_chg) begin
                    pre_d = '0;
                    pwm_d = '0;
                end else if (tick) begin
                    pre_d = '0;
                    pwm_d = pwm_q + 4'd1;
                    if (pwm_q == 4'hF) begin
                        frame_d = 1'b1;
                        char_d  = char_select;
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
        endcase

        if (debug[2]) begin
            digit_d = direct_ctrl;
        end else if (state_q == S_RUN) begin
            digit_d = pattern & {16{pwm_on}};
        end

        if (debug[1]) begin
            led_d = direct_ctrl[3:0];
        end else if (debug[0]) begin
            led_d = {pwm_on, (state_q == S_RUN), char_q};
        end else begin
            led_d = {2'b00, network_output};
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
        if (Local_Reset) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            pwm_q   <= '0;
            char_q  <= '0;
            rate_q  <= 1'b0;
            digit_q <= '0;
            led_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            pwm_q   <= pwm_d;
            char_q  <= char_d;
            rate_q  <= debug[3];
            digit_q <= digit_d;
            led_q   <= led_d;
            frame_q <= frame_d;
        end
    end

    assign digit_out   = digit_q;
    assign led_out     = led_q;
    assign frame_start = frame_q;
endmodule

// File: tb/tb_char_pwm_gen.sv
// Scoreboard bench for char_pwm_gen: an elapsed-cycle reference model predicts each
// cycle's outputs into a queue, and a monitor pops and compares after every clock edge.
module tb_char_pwm_gen;
    localparam int unsigned FREQ = 8;
    localparam int unsigned FAST = 4;
    localparam int unsigned DUTY = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cs;
    logic [15:0] dc;
    logic [31:0] dbg;
    logic [1:0]  net;
    logic [15:0] digit_out;
    logic [3:0]  led_out;
    logic        frame_start;

    char_pwm_gen #(
        .C_S_AXI_ACLK_FREQ_HZ(FREQ),
        .FAST_DIV(FAST),
        .DUTY(DUTY)
    ) dut (
        .S_AXI_ACLK(clk),
        .Local_Reset(rst),
        .char_select(cs),
        .direct_ctrl(dc),
        .debug(dbg),
        .network_output(net),
        .digit_out(digit_out),
        .led_out(led_out),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  l;
        logic        f;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: cycles elapsed since the counting restarted, plus latched character.
    bit          m_run  = 1'b0;
    bit          m_rate = 1'b0;
    logic [1:0]  m_char = 2'd0;
    int unsigned m_el   = 0;

    function automatic logic [15:0] rom(input logic [1:0] c);
        case (c)
            2'd0:    return 16'h9669;
            2'd1:    return 16'hF99F;
            2'd2:    return 16'h6FF6;
            default: return 16'h8421;
        endcase
    endfunction

    task automatic model_step();
        int unsigned div;
        int unsigned ph;
        int unsigned pwm;
        bit          chg;
        bit          on;
        bit          wrap;
        exp_t        e;
        if (rst) begin
            m_run = 1'b0; m_rate = 1'b0; m_char = 2'd0; m_el = 0;
            e = '0;
            sb_q.push_back(e);
            return;
        end
        div  = m_rate ? FREQ : FAST;
        chg  = (dbg[3] != m_rate);
        ph   = m_el % div;
        pwm  = (m_el / div) % 16;
        on   = (pwm < DUTY);
        wrap = m_run && !chg && (ph == div - 1) && (pwm == 15);
        e.d  = dbg[2] ? dc : (m_run ? (rom(m_char) & {16{on}}) : 16'h0000);
        e.l  = dbg[1] ? dc[3:0] : (dbg[0] ? {on, m_run, m_char} : {2'b00, net});
        e.f  = wrap;
        sb_q.push_back(e);
        if ((!m_run && dbg[4]) || wrap) m_char = cs;
        m_el   = (!m_run || chg) ? 0 : m_el + 1;
        m_run  = dbg[4];
        m_rate = dbg[3];
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    // One stimulus cycle: drive at the falling edge, predict, and check async reset at once.
    task automatic cyc(input logic r, input logic [31:0] d, input logic [1:0] c,
                       input logic [15:0] x, input logic [1:0] n);
        @(negedge clk);
        rst = r; dbg = d; cs = c; dc = x; net = n;
        model_step();
        if (r) begin
            #1;
            chk("reset_digit", 32'(digit_out), 32'h0);
            chk("reset_led", 32'(led_out), 32'h0);
            chk("reset_frame", 32'(frame_start), 32'h0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                tests++;
                if ({digit_out, led_out, frame_start} !== e) begin
                    fails++;
                    $display("FAIL scoreboard t=%0t digit=%h/%h led=%h/%h frame=%b/%b",
                             $time, digit_out, e.d, led_out, e.l, frame_start, e.f);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] d;
        logic [1:0]  c;
        rst = 1'b1; dbg = '0; cs = '0; dc = '0; net = '0;
        repeat (3) cyc(1'b1, 32'h0, 2'd0, 16'h0, 2'd0);

        // Basic run with character 1: two full frames.
        for (int i = 0; i < 140; i++) cyc(1'b0, 32'h10, 2'd1, 16'h0, 2'd0);
        // Character select wandering mid-frame.
        c = 2'd2;
        for (int i = 0; i < 200; i++) begin
            if ((i % 23) == 5) c = 2'($urandom);
            cyc(1'b0, 32'h10, c, 16'($urandom), 2'($urandom));
        end
        // Direct digit override in RUN and in IDLE.
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'h14, 2'd1, 16'hA5A5, 2'd0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'h04, 2'd1, 16'hA5A5, 2'd0);
        // LED sources: network result, char info with character 3, direct override.
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'h00, 2'd3, 16'h0, 2'b10);
        for (int i = 0; i < 140; i++) cyc(1'b0, 32'h11, 2'd3, 16'h0, 2'b10);
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'h12, 2'd3, 16'h0006, 2'b10);
        // Rate toggle mid-frame, then slow-rate frames.
        for (int i = 0; i < 39; i++) cyc(1'b0, 32'h10, 2'd0, 16'h0, 2'd0);
        for (int i = 0; i < 300; i++) cyc(1'b0, 32'h18, 2'd2, 16'h0, 2'd0);
        for (int i = 0; i < 50; i++) cyc(1'b0, 32'h10, 2'd1, 16'h0, 2'd0);
        // Reset pulse mid-frame while run stays requested.
        for (int i = 0; i < 30; i++) cyc(1'b0, 32'h11, 2'd2, 16'h0, 2'd0);
        cyc(1'b1, 32'h11, 2'd2, 16'h0, 2'd0);
        cyc(1'b1, 32'h11, 2'd2, 16'h0, 2'd0);
        for (int i = 0; i < 80; i++) cyc(1'b0, 32'h11, 2'd3, 16'h0, 2'd0);
        // Random soak with slowly changing modes.
        d = 32'h10;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) d[2:0] = 3'($urandom);
            if ($urandom_range(63) == 0) d[3] = ~d[3];
            if ($urandom_range(127) == 0) d[4] = 1'b0;
            else if (!d[4] && $urandom_range(7) == 0) d[4] = 1'b1;
            d[31:5] = 27'($urandom);
            cyc(1'($urandom_range(999) == 0), d, 2'($urandom), 16'($urandom), 2'($urandom));
        end

        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/char_pwm_gen.md
CHAR_PWM_GEN -- requirements
Module: char_pwm_gen

Interface
REQ-001 Parameter C_S_AXI_ACLK_FREQ_HZ, default 100000000; slow-rate divisor, giving 1 Hz ticks.
REQ-002 Parameter FAST_DIV, default 1000; fast-rate divisor in clock cycles (>=2).
REQ-003 Parameter DUTY, default 8; PWM on-steps per 16-step frame (0..16).
REQ-004 S_AXI_ACLK  input  1  clock; all logic is synchronous to its rising edge.
REQ-005 Local_Reset  input  1  reset; asynchronous, active-high.
REQ-006 char_select  input  2  requested character index from the config register block.
REQ-007 direct_ctrl  input  16  direct digit/LED override value from the config register block.
REQ-008 debug  input  32  control bits: [0] LED char-info select; [1] LED direct select; [2] digit direct select; [3] slow-rate select; [4] run enable; [31:5] ignored.
REQ-009 network_output  input  2  neuromorphic network result, already registered upstream.
REQ-010 digit_out  output  16  registered pixel drive to the ASIC inputs.
REQ-011 led_out  output  4  registered board LED drive.
REQ-012 frame_start  output  1  registered one-cycle pulse at each PWM frame wrap.

Function
REQ-013 FSM states: IDLE and RUN. IDLE->RUN when debug[4]=1. RUN->IDLE when debug[4]=0; the transition takes effect on the next edge.
REQ-014 In IDLE, prescaler, pwm_cnt and frame_start are held at 0.
REQ-015 Divisor DIV is C_S_AXI_ACLK_FREQ_HZ when debug[3]=1, else FAST_DIV.
REQ-016 In RUN, the prescaler counts 0..DIV-1. tick is asserted in the cycle where prescaler==DIV-1, and the prescaler then returns to 0.
REQ-017 A change in debug[3] (registered copy differs from input) clears the prescaler and pwm_cnt on the next edge, with no tick in that cycle.
REQ-018 pwm_cnt is 4 bits; on tick it increments, wrapping 15->0.
REQ-019 frame_start is asserted one cycle after a tick with pwm_cnt==15.
REQ-020 active_char latches char_select on each tick with pwm_cnt==15, and on IDLE->RUN entry. A char_select change mid-frame has no effect until the wrap.
REQ-021 Pattern ROM: char0=16'h9669, char1=16'hF99F, char2=16'h6FF6, char3=16'h8421.
REQ-022 pwm_on = (pwm_cnt < DUTY), unsigned compare. DUTY=0 means never on; DUTY=16 means always on.
REQ-023 digit_out selection:
  - debug[2]=1: digit_out=direct_ctrl, in any state.
  - RUN: digit_out = ROM[active_char] & {16{pwm_on}}.
  - IDLE: digit_out = 0.
  - Latency: 1 cycle from its sources.
REQ-024 led_out priority:
  - debug[1]=1: direct_ctrl[3:0].
  - else debug[0]=1: {pwm_on, state==RUN, active_char}.
  - else: {2'b00, network_output}.
  - Latency: 1 cycle.
REQ-025 Simultaneous rate change and frame wrap: the rate-change clear wins; active_char is not updated.

Reset
REQ-026 Asserting Local_Reset forces the following, independent of clock:
  - state = IDLE
  - prescaler = 0, pwm_cnt = 0
  - active_char = 0
  - registered debug[3] copy = 0
  - digit_out = 0, led_out = 0, frame_start = 0
REQ-027 Reset asserted mid-frame aborts the frame. After release, the block stays in IDLE until debug[4]=1 is sampled.

Verification (FAST_DIV=4, DUTY=8)
REQ-028 Reset, then debug=0x10, char_select=1 -> tick every 4 cycles; digit_out=16'hF99F for 8 ticks, then 0 for 8 ticks; frame_start pulses every 64 cycles.
REQ-029 char_select changes 1->2 at pwm_cnt=5 -> digit_out keeps the 16'hF99F pattern until the wrap, then switches to 16'h6FF6.
REQ-030 debug=0x14, direct_ctrl=16'hA5A5 -> digit_out=16'hA5A5 one cycle later; debug=0x04 (IDLE) -> digit_out still 16'hA5A5.
REQ-031 network_output=2'b10 with debug[1:0]=00 -> led_out=4'b0010; debug[0]=1, RUN, active_char=3, pwm_on=1 -> led_out=4'b1111; debug[1]=1, direct_ctrl[3:0]=4'h6 -> led_out=4'h6.
REQ-032 debug[3] toggled at pwm_cnt=9 -> next edge pwm_cnt=0, prescaler=0; with C_S_AXI_ACLK_FREQ_HZ=8 in the bench, ticks follow every 8 cycles.
REQ-033 Local_Reset pulsed mid-frame in RUN -> all outputs 0 immediately; state IDLE after release, even with debug[4]=1 until re-sampled.
